apr_fm_parity: RTL
==================

# apr_fm_parity

Fast-memory (FM) parity store and checker for the 36-bit AC file. It sits downstream of the six EDP slices. It takes each slice's 6-bit FM parity output (bits 00-05 … 30-35), folds them into a word parity, and keeps one stored parity bit per FM location (8 blocks × 16 ACs = 128 entries). On FM writes it records parity; on FM reads it checks it. Errors are latched as a sticky flag with a captured address and a saturating count, and are readable over the EBUS diagnostic path.

## Interface
No parameters.
- clk_apr_h  in  1  APR clock; all state changes on rising edge.
- mr_reset_h  in  1  synchronous, active-high master reset.
- edp_fm_parity_00to05_h … edp_fm_parity_30to35_h  in  6×1  per-slice parity of the current FM data.
- apr_fm_block_h  in  3  FM block {4,2,1}.
- apr_fm_adr_h  in  4  AC address {10,4,2,1}.
- fm_write_h  in  1  full-word FM write this cycle.
- fm_read_chk_h  in  1  FM read data valid this cycle; check it.
- apr_fm_par_chk_en_h  in  1  enables error latching.
- apr_clr_fm_par_err_h  in  1  clears the sticky flag, address and count.
- diag_read_func_13x_h  in  1  diagnostic read select.
- fm_parity_err_h  out  1  sticky parity error.
- fm_init_busy_h  out  1  parity-RAM initialisation in progress.
- ebus_d_h  out  36  diagnostic read data; zero when not selected.

## Operation
- Word parity is wp = XOR of the six slice inputs. The stored bit is sp = ~wp, giving odd parity. A check fails when wp ^ sp == 0.
- Index is idx = {block, adr}, 7 bits.
- The parity RAM is 128×1 and internal. Reads are synchronous, with one cycle of latency.
- The FSM has two states, INIT and RUN.
  - Reset enters INIT with ptr=0.
  - In INIT, each cycle writes 1 at ptr (the correct parity for a zero word) and increments ptr.
  - The cycle after ptr=127 is written, the FSM moves to RUN.
  - In INIT, fm_write_h and fm_read_chk_h are ignored, and no errors are latched.
- In RUN, fm_write_h writes ~wp at idx.
- In RUN, fm_read_chk_h captures wp and idx into stage-1 registers and reads sp.
  - In the next cycle, stage 1 compares the captured values.
  - A failure with apr_fm_par_chk_en_h=1 (sampled in the stage-1 cycle) sets fm_parity_err_h.
  - err_adr is loaded with the captured idx only if the flag was previously clear, so the first error wins.
  - err_cnt (4 bits) increments, saturating at 15.
- A write and a check at the same idx in the same cycle: the read returns the old stored bit (read-before-write). The written value is used from the next cycle on.
- Clear and a new error in the same cycle: the error wins. The flag stays 1, err_adr takes the new idx, and err_cnt becomes 1.
- Diag read with diag_read_func_13x_h=1:
  - ebus_d_h[0] = fm_parity_err_h
  - ebus_d_h[1] = fm_init_busy_h
  - ebus_d_h[2:8] = err_adr (MSB at bit 2)
  - ebus_d_h[9:12] = err_cnt
  - all other bits 0.
  - The output is combinational from registers.

## Timing
- Reset values: fm_parity_err_h=0, err_adr=0, err_cnt=0, fm_init_busy_h=1, ebus_d_h=0 (diag deselected). Stage-1 valid=0.
- fm_init_busy_h stays high for exactly 128 cycles after mr_reset_h deasserts, then goes low.
- Check latency: fm_read_chk_h in cycle N gives fm_parity_err_h high in cycle N+1, visible after the N+1 edge.
- One check can be accepted per cycle, fully pipelined, back to back.
- mr_reset_h asserted mid-operation:
  - Kills stage 1; no error latched from the in-flight check.
  - Clears all error state.
  - Restarts INIT at ptr=0.
- Reset held high keeps ptr=0 and busy=1.
- A write in the cycle before a check to the same idx is seen by that check.

## Test plan
- Reset, release, hold all inputs idle → fm_init_busy_h is 1 for 128 cycles then 0. Reading idx 0..127 with all slice inputs 0 → no error.
- In RUN, write idx 0x25 with slice inputs 0b000001 (wp=1), then check idx 0x25 with the same inputs → fm_parity_err_h stays 0.
- Same write, then check with inputs 0b000011 (wp=0), chk_en=1 → err=1 one cycle later, err_adr=0x25, err_cnt=1. Diag read returns bit0=1 and bits2:8=0100101.
- 20 consecutive failing checks, first at idx 0x11 then at others → err_adr=0x11, err_cnt saturates at 15. Clear in the same cycle as a failing check at 0x7F → err=1, err_adr=0x7F, err_cnt=1.
- Write and check the same idx 0x40 in one cycle, with the stored bit mismatching the new data → check uses the old bit. A check in the following cycle uses the new bit.
- Assert mr_reset_h in the cycle after a failing check request → no error latched. INIT restarts, busy=1 for 128 cycles. Writes and checks issued during INIT are ignored.

Source files
------------

// File: rtl/apr_fm_parity.sv
// FM parity store and checker for the 36-bit AC file: one odd-parity bit per FM location,
// written on FM writes, verified one cycle after FM reads, with sticky error capture.
module apr_fm_parity (
  input  logic        clk_apr_h,
  input  logic        mr_reset_h,
  input  logic        edp_fm_parity_00to05_h,
  input  logic        edp_fm_parity_06to11_h,
  input  logic        edp_fm_parity_12to17_h,
  input  logic        edp_fm_parity_18to23_h,
  input  logic        edp_fm_parity_24to29_h,
  input  logic        edp_fm_parity_30to35_h,
  input  logic [2:0]  apr_fm_block_h,
  input  logic [3:0]  apr_fm_adr_h,
  input  logic        fm_write_h,
  input  logic        fm_read_chk_h,
  input  logic        apr_fm_par_chk_en_h,
  input  logic        apr_clr_fm_par_err_h,
  input  logic        diag_read_func_13x_h,
  output logic        fm_parity_err_h,
  output logic        fm_init_busy_h,
  output logic [35:0] ebus_d_h
);

  typedef enum logic {StInit, StRun} state_e;

  state_e      state_q, state_d;
  logic [6:0]  ptr_q, ptr_d;
  logic        ram_q [128];

  logic        s1_vld_q, s1_vld_d;
  logic        s1_wp_q, s1_sp_q;
  logic [6:0]  s1_idx_q;

  logic        err_q, err_d;
  logic [6:0]  adr_q, adr_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        wp;
  logic [6:0]  idx;
  logic        chk_go;
  logic        ram_we, ram_wd;
  logic [6:0]  ram_wa;
  logic        s1_fail;

  assign wp  = edp_fm_parity_00to05_h ^ edp_fm_parity_06to11_h ^ edp_fm_parity_12to17_h ^
               edp_fm_parity_18to23_h ^ edp_fm_parity_24to29_h ^ edp_fm_parity_30to35_h;
  assign idx = {apr_fm_block_h, apr_fm_adr_h};

  assign chk_go   = (state_q == StRun) && fm_read_chk_h;
  assign s1_vld_d = chk_go;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + 7'd1;
        if (ptr_q == 7'd127) state_d = StRun;
      end
      StRun:   ;
      default: state_d = StInit;
    endcase
  end

  // INIT fills every entry with 1, the correct odd parity of an all-zero word.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = idx;
    ram_wd = ~wp;
    if (state_q == StInit) begin
      ram_we = 1'b1;
      ram_wa = ptr_q;
      ram_wd = 1'b1;
    end else if (fm_write_h) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk_apr_h) begin
    if (ram_we) ram_q[ram_wa] <= ram_wd;
  end

  // Nonblocking read alongside the write gives read-before-write at the same index.
  always_ff @(posedge clk_apr_h) begin
    if (chk_go) begin
      s1_wp_q  <= wp;
      s1_sp_q  <= ram_q[idx];
      s1_idx_q <= idx;
    end
  end

  assign s1_fail = s1_vld_q && !(s1_wp_q ^ s1_sp_q) && apr_fm_par_chk_en_h;

  always_comb begin
    err_d = err_q;
    adr_d = adr_q;
    cnt_d = cnt_q;
    if (s1_fail) begin
      err_d = 1'b1;
      if (!err_q || apr_clr_fm_par_err_h) adr_d = s1_idx_q;
      if (apr_clr_fm_par_err_h)           cnt_d = 4'd1;
      else if (cnt_q != 4'd15)            cnt_d = cnt_q + 4'd1;
    end else if (apr_clr_fm_par_err_h) begin
      err_d = 1'b0;
      adr_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_apr_h) begin
    if (mr_reset_h) begin
      state_q  <= StInit;
      ptr_q    <= '0;
      s1_vld_q <= 1'b0;
      err_q    <= 1'b0;
      adr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      s1_vld_q <= s1_vld_d;
      err_q    <= err_d;
      adr_q    <= adr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fm_parity_err_h = err_q;
  assign fm_init_busy_h  = (state_q == StInit);

  // EBUS numbering is MSB-first: the field MSB lands on the lower bit number.
  always_comb begin
    ebus_d_h = '0;
    if (diag_read_func_13x_h) begin
      ebus_d_h[0] = err_q;
      ebus_d_h[1] = fm_init_busy_h;
      for (int i = 0; i < 7; i++) ebus_d_h[2 + i] = adr_q[6 - i];
      for (int i = 0; i < 4; i++) ebus_d_h[9 + i] = cnt_q[3 - i];
    end
  end

endmodule
